// File: rtl/dec_onehot_seq_if.sv
// Code/valid handshake into the one-hot decoder plus its decoded outputs.
// master = upstream producer, slave = decoder.
interface dec_onehot_seq_if #(
  parameter int W  = 2,
  parameter int CW = 8
);
  logic              in_valid;
  logic [W-1:0]      in_code;
  logic              in_ready;
  logic [2**W-1:0]   dec_out;
  logic              dec_valid;
  logic              busy;
  logic [CW-1:0]     dec_count;

  modport master (
    output in_valid, in_code,
    input  in_ready, dec_out, dec_valid, busy, dec_count
  );

  modport slave (
    input  in_valid, in_code,
    output in_ready, dec_out, dec_valid, busy, dec_count
  );
endinterface

// File: rtl/dec_onehot_seq.sv
// Sequential binary-to-one-hot decoder: each accepted code drives one line for HOLD
// cycles, then GAP idle cycles; a one-entry pending buffer absorbs the next code.
module dec_onehot_seq #(
  parameter int W    = 2,
  parameter int HOLD = 4,
  parameter int GAP  = 1,
  parameter int CW   = 8
) (
  input logic             clk,
  input logic             rst_n,
  dec_onehot_seq_if.slave bus
);

  localparam int N    = 2**W;
  localparam int MAXC = (HOLD > GAP) ? HOLD : GAP;
  localparam int CNTW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CNTW-1:0] HOLD_LOAD = CNTW'(HOLD - 1);
  localparam logic [CNTW-1:0] GAP_LOAD  = CNTW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

  state_t          state;
  logic            pend_full;
  logic [W-1:0]    pend_code;
  logic [CNTW-1:0] cnt;
  logic [N-1:0]    dec_out;
  logic            dec_valid;
  logic [CW-1:0]   dec_count;
  logic            transfer;

  function automatic logic [N-1:0] onehot(input logic [W-1:0] code);
    onehot = N'(1) << code;
  endfunction

  assign transfer      = bus.in_valid && !pend_full;
  assign bus.in_ready  = !pend_full;
  assign bus.busy      = (state != S_IDLE) || pend_full;
  assign bus.dec_out   = dec_out;
  assign bus.dec_valid = dec_valid;
  assign bus.dec_count = dec_count;

  // A code arriving on the very edge a GAP=0 window ends chains straight into the
  // next window so streams stay gap-free; IDLE drains a buffered code left by a GAP end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pend_full <= 1'b0;
      pend_code <= '0;
      cnt       <= '0;
      dec_out   <= '0;
      dec_valid <= 1'b0;
      dec_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pend_full) begin
            state     <= S_DRIVE;
            dec_out   <= onehot(pend_code);
            dec_valid <= 1'b1;
            cnt       <= HOLD_LOAD;
            pend_full <= 1'b0;
            dec_count <= dec_count + CW'(1);
          end else if (transfer) begin
            state     <= S_DRIVE;
            dec_out   <= onehot(bus.in_code);
            dec_valid <= 1'b1;
            cnt       <= HOLD_LOAD;
            dec_count <= dec_count + CW'(1);
          end
        end

        S_DRIVE: begin
          if (cnt != '0) begin
            cnt <= cnt - CNTW'(1);
            if (transfer) begin
              pend_code <= bus.in_code;
              pend_full <= 1'b1;
            end
          end else if (GAP > 0) begin
            state     <= S_GAP;
            dec_out   <= '0;
            dec_valid <= 1'b0;
            cnt       <= GAP_LOAD;
            if (transfer) begin
              pend_code <= bus.in_code;
              pend_full <= 1'b1;
            end
          end else if (pend_full) begin
            dec_out   <= onehot(pend_code);
            cnt       <= HOLD_LOAD;
            pend_full <= 1'b0;
            dec_count <= dec_count + CW'(1);
          end else if (transfer) begin
            dec_out   <= onehot(bus.in_code);
            cnt       <= HOLD_LOAD;
            dec_count <= dec_count + CW'(1);
          end else begin
            state     <= S_IDLE;
            dec_out   <= '0;
            dec_valid <= 1'b0;
          end
        end

        S_GAP: begin
          if (transfer) begin
            pend_code <= bus.in_code;
            pend_full <= 1'b1;
          end
          if (cnt != '0) begin
            cnt <= cnt - CNTW'(1);
          end else if (pend_full) begin
            state     <= S_DRIVE;
            dec_out   <= onehot(pend_code);
            dec_valid <= 1'b1;
            cnt       <= HOLD_LOAD;
            pend_full <= 1'b0;
            dec_count <= dec_count + CW'(1);
          end else begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_onehot_seq.sv
// Directed bench for dec_onehot_seq: a HOLD=4/GAP=1 instance driven from a vector
// table, plus a HOLD=1/GAP=0/CW=2 instance for streaming and counter wrap.
module tb_dec_onehot_seq;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  dec_onehot_seq_if #(.W(2), .CW(8)) ifa ();
  dec_onehot_seq_if #(.W(2), .CW(2)) ifb ();

  dec_onehot_seq #(.W(2), .HOLD(4), .GAP(1), .CW(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  dec_onehot_seq #(.W(2), .HOLD(1), .GAP(0), .CW(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] code;
    logic [3:0] out;
    logic       valid;
    logic       rdy;
    logic       busy;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[22];

  task automatic applyStimulus(input logic sel_b, input logic v, input logic [1:0] code);
    if (sel_b) begin
      ifb.in_valid = v;
      ifb.in_code  = code;
    end else begin
      ifa.in_valid = v;
      ifa.in_code  = code;
    end
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s[%0d]: got %0h, want %0h", name, idx, act, exp);
    end
  endtask

  task automatic checkA(input string tag, input int idx, input logic [3:0] out,
                        input logic valid, input logic rdy, input logic busy,
                        input logic [7:0] cnt);
    checkOutput({tag, ".dec_out"},   idx, 32'(ifa.dec_out),   32'(out));
    checkOutput({tag, ".dec_valid"}, idx, 32'(ifa.dec_valid), 32'(valid));
    checkOutput({tag, ".in_ready"},  idx, 32'(ifa.in_ready),  32'(rdy));
    checkOutput({tag, ".busy"},      idx, 32'(ifa.busy),      32'(busy));
    checkOutput({tag, ".dec_count"}, idx, 32'(ifa.dec_count), 32'(cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_b_out [5];
    logic [1:0] exp_b_cnt [5];
    tests = 0;
    fails = 0;

    // basic decode of code 2, then back-to-back 0/3 with code 1 under backpressure
    vecs[0]  = '{1'b1, 2'd2, 4'b0100, 1'b1, 1'b1, 1'b1, 8'd1};
    vecs[1]  = '{1'b0, 2'd0, 4'b0100, 1'b1, 1'b1, 1'b1, 8'd1};
    vecs[2]  = '{1'b0, 2'd0, 4'b0100, 1'b1, 1'b1, 1'b1, 8'd1};
    vecs[3]  = '{1'b0, 2'd0, 4'b0100, 1'b1, 1'b1, 1'b1, 8'd1};
    vecs[4]  = '{1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b1, 8'd1};
    vecs[5]  = '{1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[6]  = '{1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, 1'b1, 8'd2};
    vecs[7]  = '{1'b1, 2'd3, 4'b0001, 1'b1, 1'b0, 1'b1, 8'd2};
    vecs[8]  = '{1'b1, 2'd1, 4'b0001, 1'b1, 1'b0, 1'b1, 8'd2};
    vecs[9]  = '{1'b1, 2'd1, 4'b0001, 1'b1, 1'b0, 1'b1, 8'd2};
    vecs[10] = '{1'b1, 2'd1, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd2};
    vecs[11] = '{1'b1, 2'd1, 4'b1000, 1'b1, 1'b1, 1'b1, 8'd3};
    vecs[12] = '{1'b1, 2'd1, 4'b1000, 1'b1, 1'b0, 1'b1, 8'd3};
    vecs[13] = '{1'b0, 2'd0, 4'b1000, 1'b1, 1'b0, 1'b1, 8'd3};
    vecs[14] = '{1'b0, 2'd0, 4'b1000, 1'b1, 1'b0, 1'b1, 8'd3};
    vecs[15] = '{1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd3};
    vecs[16] = '{1'b0, 2'd0, 4'b0010, 1'b1, 1'b1, 1'b1, 8'd4};
    vecs[17] = '{1'b0, 2'd0, 4'b0010, 1'b1, 1'b1, 1'b1, 8'd4};
    vecs[18] = '{1'b0, 2'd0, 4'b0010, 1'b1, 1'b1, 1'b1, 8'd4};
    vecs[19] = '{1'b0, 2'd0, 4'b0010, 1'b1, 1'b1, 1'b1, 8'd4};
    vecs[20] = '{1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b1, 8'd4};
    vecs[21] = '{1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd4};

    exp_b_out = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_b_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b0, 2'd0);
    #12;
    checkA("reset", 0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd0);
    checkOutput("reset_b.in_ready", 0, 32'(ifb.in_ready), 32'd1);
    checkOutput("reset_b.dec_count", 0, 32'(ifb.dec_count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 22; i++) begin
      applyStimulus(1'b0, vecs[i].v, vecs[i].code);
      tick();
      checkA("vec", i, vecs[i].out, vecs[i].valid, vecs[i].rdy, vecs[i].busy, vecs[i].cnt);
    end

    // asynchronous reset in the 2nd HOLD cycle with the pending buffer full
    applyStimulus(1'b0, 1'b1, 2'd2);
    tick();
    applyStimulus(1'b0, 1'b1, 2'd1);
    tick();
    checkA("pre_rst", 0, 4'b0100, 1'b1, 1'b0, 1'b1, 8'd5);
    applyStimulus(1'b0, 1'b0, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    checkA("mid_rst", 0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd0);
    #2 rst_n = 1'b1;
    tick();
    checkA("post_rst_idle", 0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, vecs[i].v, vecs[i].code);
      tick();
      checkA("post_rst", i, vecs[i].out, vecs[i].valid, vecs[i].rdy, vecs[i].busy, vecs[i].cnt);
    end

    // HOLD=1, GAP=0 stream: one pattern per cycle, 2-bit counter wraps
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 2'(i % 4));
      tick();
      checkOutput("stream.dec_out",   i, 32'(ifb.dec_out),   32'(exp_b_out[i]));
      checkOutput("stream.dec_valid", i, 32'(ifb.dec_valid), 32'd1);
      checkOutput("stream.in_ready",  i, 32'(ifb.in_ready),  32'd1);
      checkOutput("stream.dec_count", i, 32'(ifb.dec_count), 32'(exp_b_cnt[i]));
    end
    applyStimulus(1'b1, 1'b0, 2'd0);
    tick();
    checkOutput("stream_end.dec_out",   0, 32'(ifb.dec_out),   32'd0);
    checkOutput("stream_end.dec_valid", 0, 32'(ifb.dec_valid), 32'd0);
    checkOutput("stream_end.busy",      0, 32'(ifb.busy),      32'd0);
    checkOutput("stream_end.dec_count", 0, 32'(ifb.dec_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
